// File: rtl/acc_sequencer_pkg.sv
// Shared types and default widths for the accumulator sequencer.
// Holds the FSM state encoding plus the address/count widths also used by
// the accumulator that consumes acc_en / op_buffer_address.
package acc_sequencer_pkg;

    localparam int ACC_ADDR_W = 4;
    localparam int ACC_CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4
    } acc_state_t;

endpackage

// File: rtl/acc_beat_counter.sv
// Loadable up/down counter with a "count is one" terminal flag.
// Latency: one cycle from load/up/down to the new count; load wins over up, up over down.
// Ports: load/load_val, up, down in; count and last (count == 1) out.
module acc_beat_counter
    import acc_sequencer_pkg::*;
#(
    parameter int CNT_W = ACC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             up,
    input  logic             down,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (up) begin
            count <= count + CNT_W'(1);
        end else if (down) begin
            count <= count - CNT_W'(1);
        end
    end

    // When counting down, last marks the final cycle before reaching zero.
    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/acc_sequencer.sv
// Sequences one accumulate job: clear, count psum beats, wait out the adder tree, write.
// Latency: handshake N -> done in N+2+tiles+DRAIN_LAT with back-to-back beats.
// Backpressure: job_ready only in IDLE; psum beats outside ACCUM are dropped and flagged.
// Ports: job_valid/job_ready/job_tiles/job_addr handshake, psum_valid beat strobe,
// acc_en/acc_reset/op_buffer_address to the accumulator, done/busy/err_overrun status.
module acc_sequencer
    import acc_sequencer_pkg::*;
#(
    parameter int ARR_SIZE  = 4,
    parameter int ADDR_W    = ACC_ADDR_W,
    parameter int CNT_W     = ACC_CNT_W,
    parameter int DRAIN_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [CNT_W-1:0]  job_tiles,
    input  logic [ADDR_W-1:0] job_addr,
    input  logic              psum_valid,
    output logic              acc_en,
    output logic              acc_reset,
    output logic [ADDR_W-1:0] op_buffer_address,
    output logic              done,
    output logic              busy,
    output logic              err_overrun
);

    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_LAT);

    // The array width only matters to the accumulator datapath; sequencing is
    // independent of it.
    logic unused_arr_size;
    assign unused_arr_size = (ARR_SIZE > 0);

    acc_state_t        state;
    logic [CNT_W-1:0]  tiles_q;
    logic [ADDR_W-1:0] addr_q;

    logic [CNT_W-1:0]  cnt;
    logic              cnt_last;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              beat;
    logic              beat_last;

    assign beat      = (state == ST_ACCUM) && psum_valid;
    assign beat_last = beat && (cnt == tiles_q - CNT_W'(1));

    // One counter serves both phases: cleared in CLEAR, counts beats up in
    // ACCUM, and is reloaded with the drain latency on the final beat.
    assign cnt_load     = (state == ST_CLEAR) || beat_last;
    assign cnt_load_val = (state == ST_CLEAR) ? '0 : DRAIN_LD;

    acc_beat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .up       (beat),
        .down     (state == ST_DRAIN),
        .count    (cnt),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            tiles_q     <= '0;
            addr_q      <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (psum_valid && (state != ST_ACCUM)) begin
                err_overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (job_valid) begin
                        // A zero-length job still needs one beat to produce a sum.
                        tiles_q <= (job_tiles == '0) ? CNT_W'(1) : job_tiles;
                        addr_q  <= job_addr;
                        state   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: state <= ST_ACCUM;
                ST_ACCUM: begin
                    if (beat_last) begin
                        state <= (DRAIN_LAT == 0) ? ST_WRITE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_last) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign job_ready         = (state == ST_IDLE);
    assign busy              = (state != ST_IDLE);
    assign acc_reset         = (state == ST_CLEAR);
    assign acc_en            = beat;
    assign done              = (state == ST_WRITE);
    assign op_buffer_address = (state == ST_WRITE) ? addr_q : '0;

endmodule

// File: tb/tb_acc_sequencer.sv
// Randomised bench for acc_sequencer against a job-timeline reference model.
// Latency: n/a (testbench).
// Backpressure: drives job_valid while busy to confirm jobs are held off.
module tb_acc_sequencer;

    localparam int ADDR_W    = 4;
    localparam int CNT_W     = 8;
    localparam int DRAIN_LAT = 2;

    typedef logic [ADDR_W+5:0] vec_t;
    // {job_ready, busy, acc_reset, acc_en, done, err_overrun, op_buffer_address}
    localparam vec_t RST_V = {1'b1, 5'b00000, 4'd0};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              job_valid = 1'b0;
    logic              job_ready;
    logic [CNT_W-1:0]  job_tiles = '0;
    logic [ADDR_W-1:0] job_addr = '0;
    logic              psum_valid = 1'b0;
    logic              acc_en;
    logic              acc_reset;
    logic [ADDR_W-1:0] op_buffer_address;
    logic              done;
    logic              busy;
    logic              err_overrun;

    always #5 clk = ~clk;

    acc_sequencer #(
        .ARR_SIZE  (4),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .DRAIN_LAT (DRAIN_LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .job_valid         (job_valid),
        .job_ready         (job_ready),
        .job_tiles         (job_tiles),
        .job_addr          (job_addr),
        .psum_valid        (psum_valid),
        .acc_en            (acc_en),
        .acc_reset         (acc_reset),
        .op_buffer_address (op_buffer_address),
        .done              (done),
        .busy              (busy),
        .err_overrun       (err_overrun)
    );

    int vectors = 0;
    int miscompares = 0;

    // Job timeline model: k counts cycles since the handshake cycle (k=1 is
    // the clear cycle), beats accumulate from k=2 until the job's tile count is
    // reached, and done lands DRAIN_LAT+1 cycles after the last beat.
    bit              m_in_job = 0;
    int              m_k = 0;
    int              m_beats = 0;
    int              m_eff = 0;
    int              m_done_k = -1;
    logic [ADDR_W-1:0] m_addr = '0;
    bit              m_err = 0;

    vec_t exp_v;
    vec_t obs_v;
    int   en_cnt;
    int   done_cnt;

    function automatic bit m_accum();
        return m_in_job && (m_k >= 2) && (m_beats < m_eff);
    endfunction

    function automatic bit m_draining();
        return m_in_job && (m_beats == m_eff) && (m_k < m_done_k);
    endfunction

    function automatic vec_t model_expect(input bit psum);
        bit dn;
        if (!m_in_job) return {1'b1, 4'b0000, m_err, 4'd0};
        dn = (m_k == m_done_k);
        return {1'b0, 1'b1, (m_k == 1), (m_accum() && psum), dn, m_err,
                (dn ? m_addr : 4'd0)};
    endfunction

    function automatic void model_reset();
        m_in_job = 0; m_k = 0; m_beats = 0; m_eff = 0; m_done_k = -1;
        m_addr = '0; m_err = 0;
    endfunction

    // Drive one cycle of inputs, capture outputs mid-cycle, advance the model.
    task automatic drive_cycle(input bit vld, input logic [CNT_W-1:0] tiles,
                               input logic [ADDR_W-1:0] addr, input bit psum);
        bit acc_now;
        @(posedge clk);
        #1;
        job_valid  = vld;
        job_tiles  = tiles;
        job_addr   = addr;
        psum_valid = psum;
        exp_v = model_expect(psum);
        @(negedge clk);
        obs_v = {job_ready, busy, acc_reset, acc_en, done, err_overrun, op_buffer_address};
        en_cnt   += int'(acc_en);
        done_cnt += int'(done);
        acc_now = m_accum();
        if (psum && !acc_now) m_err = 1;
        if (m_in_job) begin
            if (acc_now && psum) begin
                m_beats++;
                if (m_beats == m_eff) m_done_k = m_k + DRAIN_LAT + 1;
            end
            if (m_k == m_done_k) m_in_job = 0;
            else m_k++;
        end else if (vld) begin
            m_in_job = 1; m_k = 1; m_beats = 0; m_done_k = -1;
            m_eff = (tiles == 0) ? 1 : int'(tiles);
            m_addr = addr;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        obs_v = {job_ready, busy, acc_reset, acc_en, done, err_overrun, op_buffer_address};
        vectors++;
        if (obs_v !== RST_V) begin
            miscompares++;
            $display("FAIL reset_state got=%b exp=%b", obs_v, RST_V);
        end
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        int done_at = -1;
        en_cnt = 0; done_cnt = 0;
        drive_cycle(1'b1, 8'd3, 4'd5, 1'b0);
        vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL basic c0 got=%b exp=%b", obs_v, exp_v); end
        for (int c = 1; c < 40 && m_in_job; c++) begin
            drive_cycle(1'b0, 8'd0, 4'd0, m_accum());
            if (done) done_at = c;
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL basic c%0d got=%b exp=%b", c, obs_v, exp_v); end
        end
        vectors++;
        if (done_at !== 2 + 3 + DRAIN_LAT || en_cnt !== 3) begin
            miscompares++;
            $display("FAIL basic_latency done_at=%0d acc_en_pulses=%0d exp %0d and 3", done_at, en_cnt, 2 + 3 + DRAIN_LAT);
        end
    endtask

    task automatic test_gaps();
        logic [6:0] pat = 7'b1100101;  // bit i = psum for the i-th ACCUM cycle
        int last_beat = -1;
        int done_at = -1;
        en_cnt = 0; done_cnt = 0;
        drive_cycle(1'b1, 8'd4, 4'd11, 1'b0);
        vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL gaps c0 got=%b exp=%b", obs_v, exp_v); end
        for (int c = 1; c < 40 && m_in_job; c++) begin
            bit p = (c >= 2 && c < 9) ? pat[c-2] : 1'b0;
            drive_cycle(1'b0, 8'd0, 4'd0, p);
            if (acc_en) last_beat = c;
            if (done) done_at = c;
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL gaps c%0d got=%b exp=%b", c, obs_v, exp_v); end
        end
        vectors++;
        if (en_cnt !== 4 || done_at - last_beat !== DRAIN_LAT + 1 || err_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL gaps_summary pulses=%0d done_gap=%0d err=%b exp 4,%0d,0", en_cnt, done_at - last_beat, err_overrun, DRAIN_LAT + 1);
        end
    endtask

    task automatic test_edge_jobs();
        // tiles=0 -> one beat to addr 9; then addr=0 -> done without a write
        logic [CNT_W-1:0]  t_tab [2] = '{8'd0, 8'd2};
        logic [ADDR_W-1:0] a_tab [2] = '{4'd9, 4'd0};
        int exp_en [2] = '{1, 2};
        for (int j = 0; j < 2; j++) begin
            int addr_seen = 0;
            en_cnt = 0; done_cnt = 0;
            drive_cycle(1'b1, t_tab[j], a_tab[j], 1'b0);
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL edge%0d c0 got=%b exp=%b", j, obs_v, exp_v); end
            for (int c = 1; c < 40 && m_in_job; c++) begin
                drive_cycle(1'b0, 8'd0, 4'd0, m_accum());
                if (op_buffer_address != 0) addr_seen = int'(op_buffer_address);
                vectors++;
                if (obs_v !== exp_v) begin miscompares++; $display("FAIL edge%0d c%0d got=%b exp=%b", j, c, obs_v, exp_v); end
            end
            vectors++;
            if (en_cnt !== exp_en[j] || done_cnt !== 1 || addr_seen !== int'(a_tab[j])) begin
                miscompares++;
                $display("FAIL edge%0d_summary pulses=%0d dones=%0d addr=%0d exp %0d,1,%0d", j, en_cnt, done_cnt, addr_seen, exp_en[j], a_tab[j]);
            end
        end
    endtask

    task automatic test_overrun();
        // Stray beat while idle, then a stray beat during the drain window.
        drive_cycle(1'b0, 8'd0, 4'd0, 1'b1);
        vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL ovr_idle got=%b exp=%b", obs_v, exp_v); end
        drive_cycle(1'b1, 8'd2, 4'd3, 1'b0);
        vectors++;
        if (obs_v !== exp_v || err_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got=%b exp=%b", obs_v, exp_v); end
        for (int c = 1; c < 40 && m_in_job; c++) begin
            drive_cycle(1'b0, 8'd0, 4'd0, m_accum() || m_draining());
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL ovr_drain c%0d got=%b exp=%b", c, obs_v, exp_v); end
        end
        vectors++;
        if (err_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_held got=%b exp=1", err_overrun); end
    endtask

    task automatic test_reset_mid();
        done_cnt = 0;
        drive_cycle(1'b1, 8'd3, 4'd7, 1'b0);
        drive_cycle(1'b0, 8'd0, 4'd0, 1'b0);
        drive_cycle(1'b0, 8'd0, 4'd0, 1'b1);
        vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL mid_beat got=%b exp=%b", obs_v, exp_v); end
        #2;
        rst = 1'b1;
        job_valid = 1'b0;
        psum_valid = 1'b0;
        #1;
        obs_v = {job_ready, busy, acc_reset, acc_en, done, err_overrun, op_buffer_address};
        vectors++;
        if (obs_v !== RST_V) begin miscompares++; $display("FAIL mid_async_reset got=%b exp=%b", obs_v, RST_V); end
        model_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        drive_cycle(1'b1, 8'd1, 4'd2, 1'b0);
        vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL post_reset c0 got=%b exp=%b", obs_v, exp_v); end
        for (int c = 1; c < 40 && m_in_job; c++) begin
            drive_cycle(1'b0, 8'd0, 4'd0, m_accum());
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL post_reset c%0d got=%b exp=%b", c, obs_v, exp_v); end
        end
        vectors++;
        if (done_cnt !== 1) begin miscompares++; $display("FAIL post_reset_dones got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_random();
        for (int j = 0; j < 30; j++) begin
            logic [CNT_W-1:0]  t = CNT_W'($urandom_range(0, 6));
            logic [ADDR_W-1:0] a = ADDR_W'($urandom_range(0, 15));
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                drive_cycle(1'b0, 8'd0, 4'd0, ($urandom_range(0, 15) == 0));
                vectors++;
                if (obs_v !== exp_v) begin miscompares++; $display("FAIL rnd%0d gap got=%b exp=%b", j, obs_v, exp_v); end
            end
            drive_cycle(1'b1, t, a, 1'b0);
            vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL rnd%0d c0 got=%b exp=%b", j, obs_v, exp_v); end
            for (int c = 1; c < 200 && m_in_job; c++) begin
                bit p = m_accum() ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
                // Competing job requests while busy must be held off.
                drive_cycle($urandom_range(0, 1) == 1, CNT_W'($urandom), ADDR_W'($urandom), p);
                vectors++;
                if (obs_v !== exp_v) begin miscompares++; $display("FAIL rnd%0d c%0d got=%b exp=%b", j, c, obs_v, exp_v); end
            end
            if (m_in_job) begin
                miscompares++;
                $display("FAIL rnd%0d timeout job still active", j);
                model_reset();
                rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_edge_jobs();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
